// File: rtl/lsu_wb.sv
// Load/store unit with register-file write-back over a single-cycle-ack bus.
// Optional misaligned-word trap: define LSU_ALIGN_CHECK_EN.
module lsu_wb #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [2:0]  ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_store_data,
  output logic        stall_req,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        bus_err,
  output logic        exc_misalign
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUS  = 1'b1;

  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LW  = 3'b011;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SW  = 3'b111;

  logic [0:0]  state;
  logic [7:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [4:0]  wd_q;
  logic        wreg_q;

  logic        ex_mem;
  logic        ex_word;
  logic        ex_misal;
  logic        accept_mem;
  logic        q_word;
  logic        q_store;
  logic        cnt_last;
  logic [7:0]  ld_byte;
  logic [31:0] ld_result;

  // Undefined op codes fall through to the ALU write-back path.
  assign ex_mem = ex_valid &&
                  ((ex_mem_op == OP_LB) || (ex_mem_op == OP_LBU) || (ex_mem_op == OP_LW) ||
                   (ex_mem_op == OP_SB) || (ex_mem_op == OP_SW));
  assign ex_word = (ex_mem_op == OP_LW) || (ex_mem_op == OP_SW);

`ifdef LSU_ALIGN_CHECK_EN
  logic misal_q;
  assign ex_misal     = ex_mem && ex_word && (ex_mem_addr[1:0] != 2'b00);
  assign exc_misalign = misal_q;
`else
  assign ex_misal     = 1'b0;
  assign exc_misalign = 1'b0;
`endif

  assign accept_mem = ex_mem && !ex_misal;
  assign q_word     = (op_q == OP_LW) || (op_q == OP_SW);
  assign q_store    = (op_q == OP_SB) || (op_q == OP_SW);
  assign cnt_last   = (cnt == 8'(BUS_TIMEOUT - 1));

  // Stall releases in the cycle the access completes or times out, so EX moves on that edge.
  always_comb begin
    stall_req = 1'b0;
    if (!rst) begin
      if (state == IDLE) stall_req = accept_mem;
      else               stall_req = !(bus_ack || cnt_last);
    end
  end

  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_sel   = 4'b0000;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
    if (state == BUS) begin
      bus_req  = 1'b1;
      bus_we   = q_store;
      bus_addr = addr_q;
      if (q_word) begin
        bus_addr[1:0] = 2'b00;
        bus_sel       = 4'hF;
        bus_wdata     = data_q;
      end else begin
        bus_sel   = 4'b0001 << addr_q[1:0];
        bus_wdata = {4{data_q[7:0]}};
      end
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    if (op_q == OP_LW)      ld_result = bus_rdata;
    else if (op_q == OP_LB) ld_result = {{24{ld_byte[7]}}, ld_byte};
    else                    ld_result = {24'h0, ld_byte};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'h0;
      op_q     <= 3'b000;
      addr_q   <= 32'h0;
      data_q   <= 32'h0;
      wd_q     <= 5'h0;
      wreg_q   <= 1'b0;
      wb_we    <= 1'b0;
      wb_waddr <= 5'h0;
      wb_wdata <= 32'h0;
      bus_err  <= 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
      misal_q  <= 1'b0;
`endif
    end else begin
      wb_we   <= 1'b0;
      bus_err <= 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
      misal_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (ex_misal) begin
`ifdef LSU_ALIGN_CHECK_EN
              misal_q <= 1'b1;
`endif
            end else if (ex_mem) begin
              op_q   <= ex_mem_op;
              addr_q <= ex_mem_addr;
              data_q <= ex_store_data;
              wd_q   <= ex_wd;
              wreg_q <= ex_wreg;
              cnt    <= 8'h0;
              state  <= BUS;
            end else begin
              wb_we    <= ex_wreg;
              wb_waddr <= ex_wd;
              wb_wdata <= ex_wdata;
            end
          end
        end
        BUS: begin
          // An ack in the last allowed cycle still counts as success.
          if (bus_ack) begin
            if (!q_store) begin
              wb_we    <= wreg_q;
              wb_waddr <= wd_q;
              wb_wdata <= ld_result;
            end
            cnt   <= 8'h0;
            state <= IDLE;
          end else if (cnt_last) begin
            bus_err <= 1'b1;
            cnt     <= 8'h0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 8'h1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_wb.sv
// Scoreboard bench for lsu_wb: stimulus pushes expected write-back/error/trap events,
// a negedge monitor pops them as the DUT produces them.
module tb_lsu_wb;

  localparam int T = 16;
`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  localparam int EV_WB  = 0;
  localparam int EV_ERR = 1;
  localparam int EV_MIS = 2;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [2:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic        stall_req;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        bus_err;
  logic        exc_misalign;

  lsu_wb #(.BUS_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .stall_req(stall_req),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_sel(bus_sel), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .bus_err(bus_err), .exc_misalign(exc_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic pushExp(input int kind, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = kind;
    e.waddr = a;
    e.wdata = d;
    expq.push_back(e);
  endtask

  task automatic popCheck(input int kind, input string name);
    exp_t e;
    if (expq.size() == 0) begin
      checkOutput({"unexpected_", name}, 32'd1, 32'd0);
    end else begin
      e = expq.pop_front();
      checkOutput({name, "_kind"}, 32'(kind), 32'(e.kind));
      if (kind == EV_WB && e.kind == EV_WB) begin
        checkOutput("wb_waddr", 32'(wb_waddr), 32'(e.waddr));
        checkOutput("wb_wdata", wb_wdata, e.wdata);
      end
    end
  endtask

  // Reference model of the load path, straight from the byte-lane rules.
  function automatic logic [31:0] loadModel(input logic [2:0] op, input logic [31:0] addr,
                                            input logic [31:0] rdata);
    logic [31:0] b;
    if (op == 3'b011) return rdata;
    b = (rdata >> (8 * int'(addr[1:0]))) & 32'hFF;
    if (op == 3'b001 && b >= 32'd128) return b | 32'hFFFF_FF00;
    return b;
  endfunction

  function automatic bit isMemOp(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b010) || (op == 3'b011) || (op == 3'b101) || (op == 3'b111);
  endfunction

  // Monitor: every event the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_we)        popCheck(EV_WB, "wb");
      if (bus_err)      popCheck(EV_ERR, "bus_err");
      if (exc_misalign) popCheck(EV_MIS, "exc_misalign");
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic applyStimulus(input logic [2:0] op, input logic [4:0] wd, input logic wreg,
                               input logic [31:0] wdata, input logic [31:0] addr,
                               input logic [31:0] sdata, input int ack_at,
                               input logic [31:0] rdata);
    bit mem, word, store, mis;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_sel;
    mem   = isMemOp(op);
    word  = (op == 3'b011) || (op == 3'b111);
    store = (op == 3'b101) || (op == 3'b111);
    mis   = ALIGN_CHK && mem && word && (addr[1:0] != 2'b00);
    ex_valid = 1'b1; ex_mem_op = op; ex_wd = wd; ex_wreg = wreg;
    ex_wdata = wdata; ex_mem_addr = addr; ex_store_data = sdata;
    bus_ack = 1'b0;
    @(negedge clk);
    checkOutput("stall_issue", 32'(stall_req), 32'(mem && !mis));
    if (!mem) begin
      if (wreg) pushExp(EV_WB, wd, wdata);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      return;
    end
    if (mis) begin
      pushExp(EV_MIS, 5'd0, 32'd0);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      @(negedge clk);
      checkOutput("misalign_no_req", 32'(bus_req), 32'd0);
      @(posedge clk); #1;
      return;
    end
    e_addr  = word ? (addr & 32'hFFFF_FFFC) : addr;
    e_sel   = word ? 4'hF : 4'(4'b0001 << addr[1:0]);
    e_wdata = word ? sdata : (sdata & 32'hFF) * 32'h0101_0101;
    @(posedge clk); #1;
    // Junk on the EX side while busy must be ignored.
    ex_valid = 1'b1; ex_mem_op = 3'b000; ex_wreg = 1'b1;
    ex_wd = 5'($urandom); ex_wdata = $urandom; ex_mem_addr = $urandom;
    for (int k = 0; k < T; k++) begin
      bus_ack   = (k == ack_at);
      bus_rdata = bus_ack ? rdata : $urandom;
      @(negedge clk);
      checkOutput("bus_req", 32'(bus_req), 32'd1);
      if (k == 0 || bus_ack || k == T - 1) begin
        checkOutput("bus_addr", bus_addr, e_addr);
        checkOutput("bus_sel", 32'(bus_sel), 32'(e_sel));
        checkOutput("bus_we", 32'(bus_we), 32'(store));
        if (store) checkOutput("bus_wdata", bus_wdata, e_wdata);
      end
      checkOutput("stall_bus", 32'(stall_req), 32'(!(bus_ack || k == T - 1)));
      if (bus_ack) begin
        if (!store && wreg) pushExp(EV_WB, wd, loadModel(op, addr, rdata));
        @(posedge clk); #1;
        bus_ack = 1'b0; ex_valid = 1'b0;
        return;
      end
      if (k == T - 1) begin
        pushExp(EV_ERR, 5'd0, 32'd0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        checkOutput("bus_req_drop", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [2:0] op_tab [8];
    op_tab = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b111, 3'b100, 3'b110};
    rst = 1'b1; ex_valid = 1'b0; ex_wd = 5'd0; ex_wreg = 1'b0; ex_wdata = 32'd0;
    ex_mem_op = 3'b000; ex_mem_addr = 32'd0; ex_store_data = 32'd0;
    bus_rdata = 32'd0; bus_ack = 1'b0;

    #3;
    checkOutput("rst_stall", 32'(stall_req), 32'd0);
    checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
    checkOutput("rst_bus_addr", bus_addr, 32'd0);
    checkOutput("rst_bus_sel", 32'(bus_sel), 32'd0);
    checkOutput("rst_wb_we", 32'(wb_we), 32'd0);
    checkOutput("rst_wb_wdata", wb_wdata, 32'd0);
    checkOutput("rst_bus_err", 32'(bus_err), 32'd0);
    checkOutput("rst_exc_misalign", 32'(exc_misalign), 32'd0);
    ex_valid = 1'b1; ex_mem_op = 3'b011;
    #1;
    checkOutput("rst_stall_memop", 32'(stall_req), 32'd0);
    ex_valid = 1'b0; ex_mem_op = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed cases");
    applyStimulus(3'b000, 5'd3, 1'b1, 32'h1234, 32'h0, 32'h0, 0, 32'h0);
    applyStimulus(3'b001, 5'd7, 1'b1, 32'h0, 32'h102, 32'h0, 2, 32'h0080_0000);
    applyStimulus(3'b010, 5'd8, 1'b1, 32'h0, 32'h102, 32'h0, 2, 32'h0080_0000);
    applyStimulus(3'b101, 5'd9, 1'b1, 32'h0, 32'h203, 32'h1234_56AB, 1, 32'h0);
    applyStimulus(3'b011, 5'd10, 1'b1, 32'h0, 32'h40, 32'h0, T, 32'h0);
    applyStimulus(3'b011, 5'd11, 1'b1, 32'h0, 32'h44, 32'h0, T - 1, 32'hCAFE_F00D);
    applyStimulus(3'b011, 5'd12, 1'b1, 32'h0, 32'h101, 32'h0, 0, 32'h1122_3344);
    applyStimulus(3'b000, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 32'h0);
    applyStimulus(3'b111, 5'd13, 1'b1, 32'h0, 32'h80, 32'h5566_7788, 0, 32'h0);

    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge clk);
      checkOutput("idle_ack_no_req", 32'(bus_req), 32'd0);
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;

    ex_valid = 1'b1; ex_mem_op = 3'b011; ex_mem_addr = 32'h80; ex_wd = 5'd5; ex_wreg = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checkOutput("midbus_rst_bus_req", 32'(bus_req), 32'd0);
    checkOutput("midbus_rst_stall", 32'(stall_req), 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] random cases");
    for (int i = 0; i < 300; i++) begin
      int ack_at;
      ack_at = ($urandom_range(0, 9) == 0) ? T + 1 : int'($urandom_range(0, T - 1));
      if ($urandom_range(0, 7) == 0) ack_at = T - 1;
      applyStimulus(op_tab[$urandom_range(0, 7)], 5'($urandom), 1'($urandom),
                    $urandom, $urandom, $urandom, ack_at, $urandom);
    end

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_wb.md
LSU_WB -- requirements
Module: lsu_wb

Interface
Parameters:
REQ-001 SHALL have parameter BUS_TIMEOUT, default 16: maximum cycles in BUS awaiting bus_ack (range 1..255).
Ports:
REQ-002 SHALL have clk  input  1  sole clock, rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high (rst==1 resets).
REQ-004 SHALL have ex_valid  input  1  EX presents an instruction this cycle.
REQ-005 SHALL have ex_wd  input  5  destination register address.
REQ-006 SHALL have ex_wreg  input  1  instruction writes ex_wd.
REQ-007 SHALL have ex_wdata  input  32  ALU result, used for non-memory ops.
REQ-008 SHALL have ex_mem_op  input  3  encoded as 000 NONE, 001 LB, 010 LBU, 011 LW, 101 SB, 111 SW; other codes are treated as NONE.
REQ-009 SHALL have ex_mem_addr  input  32  byte address.
REQ-010 SHALL have ex_store_data  input  32  store operand.
REQ-011 SHALL have stall_req  output  1  EX must hold its instruction.
REQ-012 SHALL have bus_req, bus_we  outputs  1 each  bus request and write qualifier.
REQ-013 SHALL have bus_addr, bus_wdata  outputs  32 each; bus_sel  output  4  byte lanes.
REQ-014 SHALL have bus_rdata  input  32 and bus_ack  input  1  single-cycle completion.
REQ-015 SHALL have wb_we  output  1, wb_waddr  output  5, wb_wdata  output  32, driving the register-file write port.
REQ-016 SHALL have bus_err  output  1  one-cycle timeout pulse; exc_misalign  output  1  (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE and BUS.
REQ-018 SHALL, in IDLE with ex_valid and op NONE, register wb_we=ex_wreg, wb_waddr=ex_wd, wb_wdata=ex_wdata at the next edge (1-cycle latency), with stall_req=0.
REQ-019 SHALL, in IDLE with ex_valid and a memory op, drive stall_req=1 combinationally, capture op/addr/data/wd/wreg, and enter BUS.
REQ-020 SHALL, in BUS, hold bus_req=1 with bus_addr/bus_we/bus_sel/bus_wdata stable until bus_ack or timeout, and ignore ex_* inputs.
REQ-021 SHALL keep stall_req=1 in BUS except in the cycle bus_ack=1 or the timeout fires, where stall_req=0 so that EX advances on that edge.
REQ-022 SHALL drive bus_sel=1<<addr[1:0] for byte ops (little-endian) and 4'hF for word ops; SB replicates store_data[7:0] on all four lanes.
REQ-023 SHALL, on load bus_ack, select byte addr[1:0] for LB (sign-extend) or LBU (zero-extend), or the full word for LW, and register wb_we=wreg, wb_waddr=wd, wb_wdata=result at the same edge, returning to IDLE.
REQ-024 SHALL never assert wb_we for stores; on store bus_ack it SHALL return to IDLE.
REQ-025 SHALL keep wb_we=0 in every cycle that does not follow a retirement edge.
REQ-026 SHALL, after BUS_TIMEOUT cycles in BUS without bus_ack: drop bus_req, pulse bus_err for 1 cycle, suppress write-back, and return to IDLE.
REQ-027 SHALL treat bus_ack in the final timeout cycle as success, with no bus_err.
REQ-028 SHALL pass wd==0 through unchanged; the register file discards the write.
REQ-029 SHALL ignore bus_ack while in IDLE.

Reset
REQ-030 SHALL, while rst=1 and independent of clk, force IDLE, timeout counter 0, and stall_req, bus_req, bus_we, bus_sel, bus_addr, bus_wdata, wb_we, wb_waddr, wb_wdata, bus_err, exc_misalign all to 0.
REQ-031 SHALL abandon any in-flight access on reset without a write-back.

Configuration
REQ-032 SHALL, with LSU_ALIGN_CHECK_EN defined, detect LW/SW with addr[1:0]!=0 in the IDLE capture cycle, issue no bus access, pulse exc_misalign for 1 cycle at the next edge, suppress write-back, keep stall_req=0, and stay in IDLE.
REQ-033 SHALL, without LSU_ALIGN_CHECK_EN, force bus_addr[1:0]=0 for word ops and tie exc_misalign to 0.

Verification
REQ-034 SHALL cover: ALU op wd=3, wdata=0x1234 -> next cycle wb_we=1, waddr=3, wdata=0x1234, stall_req=0.
REQ-035 SHALL cover: LB at addr 0x102, rdata=0x0080_0000, ack after 2 cycles -> bus_sel=4'b0100, wb_wdata=0xFFFFFF80; the same access as LBU -> wb_wdata=0x00000080.
REQ-036 SHALL cover: SB of 0xAB at 0x203 -> bus_sel=4'b1000, bus_wdata=0xABABABAB, bus_we=1, no wb_we.
REQ-037 SHALL cover: no ack with BUS_TIMEOUT=16 -> bus_req drops after 16 cycles, bus_err 1-cycle pulse, wb_we=0.
REQ-038 SHALL cover: rst asserted mid-BUS -> bus_req=0 and stall_req=0 immediately, no write-back after release.
REQ-039 SHALL cover: LW at 0x101 -> with LSU_ALIGN_CHECK_EN, exc_misalign pulse and no bus_req; without it, bus_addr=0x100.
